// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding load/store, valid/ready request side,
// single-cycle response pulse carrying read data or an error flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;

    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          enter_resp;
    logic          eff_write;
    logic [31:0]   eff_addr;
    logic [31:0]   eff_wdata;
    logic [AW-1:0] eff_index;
    logic          eff_err;

    assign accept     = (state == S_IDLE) && req_valid_i;
    assign enter_resp = (next_state == S_RESP);

    // With LATENCY=1 the commit edge is the accept edge, so the live inputs stand in for the captured copy.
    assign eff_write = (state == S_IDLE) ? req_write_i : cap_write;
    assign eff_addr  = (state == S_IDLE) ? req_addr_i  : cap_addr;
    assign eff_wdata = (state == S_IDLE) ? req_wdata_i : cap_wdata;
    assign eff_index = eff_addr[AW+1:2];
    assign eff_err   = (|eff_addr[1:0]) || (|eff_addr[31:AW+2]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_WAIT) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (accept) begin
                cap_write <= req_write_i;
                cap_addr  <= req_addr_i;
                cap_wdata <= req_wdata_i;
            end
            if (enter_resp) begin
                err_q   <= eff_err;
                rdata_q <= (!eff_err && !eff_write) ? mem[eff_index] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (enter_resp && eff_write && !eff_err) begin
            mem[eff_index] <= eff_wdata;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state == S_IDLE);
        busy_o       = (state == S_WAIT);
        resp_valid_o = (state == S_RESP);
        resp_rdata_o = (state == S_RESP) ? rdata_q : 32'h0;
        resp_err_o   = (state == S_RESP) ? err_q : 1'b0;
    end

endmodule
